// File: rtl/seg_scan_monitor_if.sv
// Bus between a multiplexed 7-segment clock display scanner and the monitor that decodes it.
// master drives the scan lines, slave decodes them and presents the time.
interface seg_scan_monitor_if;
   logic [5:0] sm_bit;
   logic [7:0] sm_seg;
   logic [3:0] hr_h;
   logic [3:0] hr_l;
   logic [3:0] min_h;
   logic [3:0] min_l;
   logic [3:0] sec_h;
   logic [3:0] sec_l;
   logic       frame_valid;
   logic       code_err;
   logic       timeout;

   modport master (
      output sm_bit, sm_seg,
      input  hr_h, hr_l, min_h, min_l, sec_h, sec_l, frame_valid, code_err, timeout
   );

   modport slave (
      input  sm_bit, sm_seg,
      output hr_h, hr_l, min_h, min_l, sec_h, sec_l, frame_valid, code_err, timeout
   );
endinterface

// File: rtl/seg_scan_monitor.sv
// Watches a scanned six-digit 7-segment display, captures each digit once it has been stable,
// and publishes complete HH:MM:SS frames in BCD along with error and timeout indications.
module seg_scan_monitor #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic            clk,
   input logic            rst,
   seg_scan_monitor_if.slave bus
);

   localparam logic [7:0]  STABLE_LAST  = 8'(STABLE_CYCLES - 1);
   localparam logic [23:0] TIMEOUT_MAX  = 24'(TIMEOUT_CYCLES);
   localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [5:0]  bit_q;
   logic [6:0]  seg_q;
   logic [5:0]  sel_n;
   logic        sel_valid;
   logic        same_ref;

   logic [5:0]  ref_bit;
   logic [6:0]  ref_seg;
   logic        ref_load;

   logic [7:0]  stable_cnt;
   logic [7:0]  stable_next;
   logic        capture;

   logic [3:0]  dec_digit;
   logic        dec_ok;

   logic [3:0]  shadow [6];
   logic [3:0]  digit  [6];
   logic [5:0]  captured_mask;
   logic [5:0]  mask_next;
   logic        frame_done;

   logic [23:0] timeout_cnt;
   logic        first_sat;

   logic        frame_valid_q;
   logic        code_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_q <= 6'h3F;
         seg_q <= 7'h7F;
      end else begin
         bit_q <= bus.sm_bit;
         seg_q <= bus.sm_seg[6:0];
      end
   end

   // A select is usable only when exactly one digit line is pulled low.
   assign sel_n     = ~bit_q;
   assign sel_valid = $onehot(sel_n);
   assign same_ref  = (bit_q == ref_bit) && (seg_q == ref_seg);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         stable_cnt <= 8'd0;
         ref_bit    <= 6'h3F;
         ref_seg    <= 7'h7F;
      end else begin
         state      <= state_next;
         stable_cnt <= stable_next;
         if (ref_load) begin
            ref_bit <= bit_q;
            ref_seg <= seg_q;
         end
      end
   end

   always_comb begin
      state_next  = state;
      stable_next = stable_cnt;
      ref_load    = 1'b0;
      capture     = 1'b0;
      unique case (state)
         IDLE: begin
            if (sel_valid) begin
               state_next  = SETTLE;
               stable_next = 8'd1;
               ref_load    = 1'b1;
            end
         end
         SETTLE: begin
            if (same_ref) begin
               stable_next = stable_cnt + 8'd1;
               if (stable_cnt == STABLE_LAST) begin
                  capture    = 1'b1;
                  state_next = HOLD;
               end
            end else if (sel_valid) begin
               stable_next = 8'd1;
               ref_load    = 1'b1;
            end else begin
               state_next  = IDLE;
               stable_next = 8'd0;
            end
         end
         HOLD: begin
            // The slot has been captured; wait for the scanner to move on before re-arming.
            if (!same_ref) begin
               state_next  = IDLE;
               stable_next = 8'd0;
            end
         end
         default: begin
            state_next  = IDLE;
            stable_next = 8'd0;
         end
      endcase
   end

   always_comb begin
      dec_ok    = 1'b1;
      dec_digit = 4'hF;
      case (ref_seg)
         7'h40:   dec_digit = 4'd0;
         7'h79:   dec_digit = 4'd1;
         7'h24:   dec_digit = 4'd2;
         7'h30:   dec_digit = 4'd3;
         7'h19:   dec_digit = 4'd4;
         7'h12:   dec_digit = 4'd5;
         7'h02:   dec_digit = 4'd6;
         7'h78:   dec_digit = 4'd7;
         7'h00:   dec_digit = 4'd8;
         7'h10:   dec_digit = 4'd9;
         default: begin
            dec_ok    = 1'b0;
            dec_digit = 4'hF;
         end
      endcase
   end

   // A capture beats both the frame-complete clear and the timeout clear, so no digit is lost.
   assign frame_done = (captured_mask == 6'h3F);
   assign first_sat  = !capture && (timeout_cnt == TIMEOUT_LAST);

   always_comb begin
      mask_next = captured_mask;
      if (frame_done || first_sat) begin
         mask_next = 6'h00;
      end
      if (capture) begin
         mask_next = mask_next | ~ref_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         captured_mask <= 6'h00;
         timeout_cnt   <= 24'd0;
         frame_valid_q <= 1'b0;
         code_err_q    <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            shadow[i] <= 4'h0;
            digit[i]  <= 4'h0;
         end
      end else begin
         captured_mask <= mask_next;
         frame_valid_q <= frame_done;
         code_err_q    <= capture && !dec_ok;
         if (frame_done) begin
            for (int i = 0; i < 6; i++) begin
               digit[i] <= shadow[i];
            end
         end
         if (capture) begin
            for (int i = 0; i < 6; i++) begin
               if (!ref_bit[i]) begin
                  shadow[i] <= dec_digit;
               end
            end
         end
         if (capture) begin
            timeout_cnt <= 24'd0;
         end else if (timeout_cnt != TIMEOUT_MAX) begin
            timeout_cnt <= timeout_cnt + 24'd1;
         end
      end
   end

   assign bus.sec_l       = digit[0];
   assign bus.sec_h       = digit[1];
   assign bus.min_l       = digit[2];
   assign bus.min_h       = digit[3];
   assign bus.hr_l        = digit[4];
   assign bus.hr_h        = digit[5];
   assign bus.frame_valid = frame_valid_q;
   assign bus.code_err    = code_err_q;
   assign bus.timeout     = (timeout_cnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Directed bench for seg_scan_monitor: expected frames and code errors go into queues,
// and an independent monitor pops them whenever the DUT pulses frame_valid or code_err.
module tb_seg_scan_monitor;

   localparam int STABLE  = 16;
   localparam int TIMEOUT = 200;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seg_scan_monitor_if bus ();

   seg_scan_monitor #(
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Frames are packed {hr_h,hr_l,min_h,min_l,sec_h,sec_l}, so scan position p sits at [4p+:4].
   logic [23:0] frame_q [$];
   bit          ce_q    [$];
   int          compared   = 0;
   int          mismatched = 0;

   logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [23:0] digits;

   assign digits = {bus.hr_h, bus.hr_l, bus.min_h, bus.min_l, bus.sec_h, bus.sec_l};

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic checkQueues(input string name);
      checkOutput({name, "_frames_pending"}, 32'(frame_q.size()), 32'd0);
      checkOutput({name, "_code_err_pending"}, 32'(ce_q.size()), 32'd0);
   endtask

   task automatic applyStimulus(input logic [5:0] bits, input logic [7:0] seg, input int cycles);
      @(negedge clk);
      bus.sm_bit = bits;
      bus.sm_seg = seg;
      repeat (cycles - 1) @(negedge clk);
   endtask

   task automatic scanDigit(input int pos, input logic [3:0] val, input int cycles);
      logic [5:0] one;
      logic [7:0] seg;
      one = 6'b000001 << pos;
      seg = (val <= 4'd9) ? {1'b1, seg_tab[int'(val)]} : 8'hFF;
      applyStimulus(~one, seg, cycles);
   endtask

   task automatic scanFrame(input logic [23:0] f, input int hold, input bit reverse);
      int pos;
      for (int k = 0; k < 6; k++) begin
         pos = reverse ? 5 - k : k;
         scanDigit(pos, f[4*pos +: 4], hold);
      end
   endtask

   task automatic idle(input int cycles);
      applyStimulus(6'h3F, 8'hFF, cycles);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.frame_valid) begin
            compared++;
            if (frame_q.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpected_frame: got %06h required none", digits);
            end else if (digits !== frame_q[0]) begin
               mismatched++;
               $display("[TB] FAIL frame: got %06h required %06h", digits, frame_q[0]);
               void'(frame_q.pop_front());
            end else begin
               void'(frame_q.pop_front());
            end
         end
         if (bus.code_err) begin
            compared++;
            if (ce_q.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpected_code_err: got 1 required 0");
            end else begin
               void'(ce_q.pop_front());
            end
         end
      end
   end

   initial begin
      bus.sm_bit = 6'h3F;
      bus.sm_seg = 8'hFF;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_digits", 32'(digits), 32'h0);
      checkOutput("reset_frame_valid", 32'(bus.frame_valid), 32'd0);
      checkOutput("reset_code_err", 32'(bus.code_err), 32'd0);
      checkOutput("reset_timeout", 32'(bus.timeout), 32'd0);

      $display("[TB] scan 12:34:56");
      frame_q.push_back(24'h123456);
      scanFrame(24'h123456, 40, 1'b0);
      idle(20);
      checkQueues("t_123456");
      checkOutput("t_123456_hold", 32'(digits), 32'h123456);

      $display("[TB] blank sec_l");
      frame_q.push_back(24'h12345F);
      ce_q.push_back(1'b1);
      scanFrame(24'h12345F, 40, 1'b0);
      idle(20);
      checkQueues("t_blank");

      $display("[TB] reset mid-frame");
      for (int p = 0; p < 4; p++) begin
         scanDigit(p, 4'(p + 4), 40);
      end
      idle(1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_digits", 32'(digits), 32'h0);
      checkOutput("midrst_timeout", 32'(bus.timeout), 32'd0);
      checkOutput("midrst_frame_valid", 32'(bus.frame_valid), 32'd0);
      frame_q.push_back(24'h000009);
      scanFrame(24'h000009, 40, 1'b1);
      idle(20);
      checkQueues("t_000009");
      checkOutput("t_000009_digits", 32'(digits), 32'h000009);

      $display("[TB] stalled scan then resume");
      scanDigit(0, 4'd1, 40);
      scanDigit(1, 4'd2, 40);
      scanDigit(2, 4'd3, 40);
      idle(TIMEOUT + 10);
      checkOutput("stall_timeout_set", 32'(bus.timeout), 32'd1);
      frame_q.push_back(24'h235947);
      scanDigit(5, 4'd2, 40);
      checkOutput("resume_timeout_clear", 32'(bus.timeout), 32'd0);
      scanDigit(4, 4'd3, 40);
      scanDigit(3, 4'd5, 40);
      scanDigit(2, 4'd9, 40);
      scanDigit(1, 4'd4, 40);
      scanDigit(0, 4'd7, 40);
      idle(20);
      checkQueues("t_resume");

      $display("[TB] glitching scan");
      for (int r = 0; r < 5; r++) begin
         for (int p = 0; p < 6; p++) begin
            scanDigit(p, 4'(p + 1), 10);
            idle(1);
         end
         if (r == 0) begin
            checkOutput("glitch_timeout_early", 32'(bus.timeout), 32'd0);
         end
      end
      checkOutput("glitch_timeout_late", 32'(bus.timeout), 32'd1);
      checkQueues("t_glitch");

      $display("[TB] two selects low");
      applyStimulus(6'b111100, {1'b1, seg_tab[8]}, 100);
      idle(5);
      checkOutput("twolow_timeout_kept", 32'(bus.timeout), 32'd1);
      checkQueues("t_twolow");

      $display("[TB] stability boundary");
      scanDigit(0, 4'd3, STABLE - 1);
      idle(5);
      checkOutput("stable_short_no_capture", 32'(bus.timeout), 32'd1);
      scanDigit(0, 4'd3, STABLE);
      idle(2);
      checkOutput("stable_exact_capture", 32'(bus.timeout), 32'd0);
      idle(10);
      checkQueues("t_boundary");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
